// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side driver for the 8-bit ALU datapath.
// Accepts an opcode/operand request, drives registered operands and a one-hot
// select into the combinational ALU for a programmable settle window, then
// captures the ALU answer and returns it over a valid/ready response channel.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [7:0]       cmd_op1,
    input  logic [7:0]       cmd_op2,
    output logic [7:0]       alu_op1,
    output logic [7:0]       alu_op2,
    output logic [7:0]       alu_sel,
    input  logic [7:0]       alu_ans,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [2:0]       rsp_opcode,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Settle counter preload: DRIVE lasts SETTLE_CYCLES edges including the capture edge.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       opc_q, opc_d;
    logic [7:0]       op1_q, op1_d;
    logic [7:0]       op2_q, op2_d;
    logic [7:0]       sel_q, sel_d;
    logic             rv_q, rv_d;
    logic [7:0]       rd_q, rd_d;
    logic [2:0]       ro_q, ro_d;
    logic             crdy_q, crdy_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    // Opcode n maps to select bit n; exactly one bit is ever set.
    function automatic logic [7:0] onehot(input logic [2:0] code);
        logic [7:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // Next-state and next-output decode; every register defaults to holding.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sel_d   = sel_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
        ro_d    = ro_q;
        ops_d   = ops_q;

        case (state_q)
            IDLE: begin
                sel_d = '0;
                if (cmd_valid) begin
                    opc_d   = cmd_opcode;
                    op1_d   = cmd_op1;
                    op2_d   = cmd_op2;
                    sel_d   = onehot(cmd_opcode);
                    cnt_d   = CNT_LOAD;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rd_d    = alu_ans;
                    ro_d    = opc_q;
                    rv_d    = 1'b1;
                    sel_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    ops_d   = ops_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                rv_d    = 1'b0;
            end
        endcase

        // Handshake/status flags follow the next state so they are registered too.
        crdy_d = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sel_q   <= '0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            ro_q    <= '0;
            crdy_q  <= 1'b1;
            busy_q  <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sel_q   <= sel_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            ro_q    <= ro_d;
            crdy_q  <= crdy_d;
            busy_q  <= busy_d;
            ops_q   <= ops_d;
        end
    end

    assign cmd_ready  = crdy_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = rv_q;
    assign rsp_data   = rd_q;
    assign rsp_opcode = ro_q;
    assign busy       = busy_q;
    assign op_count   = ops_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table vectors, randomized
// transactions against a reference model, and hand-written corner sequences.
module tb_alu_op_sequencer;

    localparam int unsigned S0 = 2;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: SETTLE_CYCLES=2, 4-bit counter for the wrap test.
    logic          cmd_valid0 = 1'b0, rsp_ready0 = 1'b0;
    logic [2:0]    cmd_opcode0 = '0;
    logic [7:0]    cmd_op1_0 = '0, cmd_op2_0 = '0;
    logic          cmd_ready0, rsp_valid0, busy0;
    logic [7:0]    alu_op1_0, alu_op2_0, alu_sel0, alu_ans0, rsp_data0;
    logic [2:0]    rsp_opcode0;
    logic [CW-1:0] op_count0;

    // Second instance: SETTLE_CYCLES=1 boundary.
    logic          cmd_valid1 = 1'b0, rsp_ready1 = 1'b1;
    logic [2:0]    cmd_opcode1 = '0;
    logic [7:0]    cmd_op1_1 = '0, cmd_op2_1 = '0;
    logic          cmd_ready1, rsp_valid1, busy1;
    logic [7:0]    alu_op1_1, alu_op2_1, alu_sel1, alu_ans1, rsp_data1;
    logic [2:0]    rsp_opcode1;
    logic [15:0]   op_count1;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    // Reference ALU behaviour by opcode.
    function automatic logic [7:0] ref_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return {a[6:0], 1'b0};
            3'd3:    return {1'b0, a[7:1]};
            3'd4:    return a ^ b;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return ~a;
        endcase
    endfunction

    // Combinational ALU stand-in; a non-one-hot select yields a junk value.
    function automatic logic [7:0] alu_model(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'hEE;
        for (int i = 0; i < 8; i++)
            if (sel == (8'd1 << i)) r = ref_fn(3'(i), a, b);
        return r;
    endfunction

    assign alu_ans0 = alu_model(alu_sel0, alu_op1_0, alu_op2_0);
    assign alu_ans1 = alu_model(alu_sel1, alu_op1_1, alu_op2_1);

    alu_op_sequencer #(.SETTLE_CYCLES(S0), .CNT_W(CW)) u0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_opcode(cmd_opcode0),
        .cmd_op1(cmd_op1_0), .cmd_op2(cmd_op2_0),
        .alu_op1(alu_op1_0), .alu_op2(alu_op2_0), .alu_sel(alu_sel0), .alu_ans(alu_ans0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .rsp_opcode(rsp_opcode0), .busy(busy0), .op_count(op_count0)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_opcode(cmd_opcode1),
        .cmd_op1(cmd_op1_1), .cmd_op2(cmd_op2_1),
        .alu_op1(alu_op1_1), .alu_op2(alu_op2_1), .alu_sel(alu_sel1), .alu_ans(alu_ans1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_opcode(rsp_opcode1), .busy(busy1), .op_count(op_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction on u0: accept, settle, respond, optional stall, handshake.
    task automatic do_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input logic [7:0] expd);
        int k;
        logic [7:0] held;
        logic [7:0] esel;
        esel = 8'd1 << op;
        @(negedge clk);
        k = 0;
        while (!cmd_ready0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready_idle", {31'd0, cmd_ready0}, 32'd1);
        chk("sel_idle", {24'd0, alu_sel0}, 32'd0);
        cmd_valid0 = 1'b1; cmd_opcode0 = op; cmd_op1_0 = a; cmd_op2_0 = b;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        cmd_opcode0 = 3'($urandom); cmd_op1_0 = 8'($urandom); cmd_op2_0 = 8'($urandom);
        k = 0;
        while (!rsp_valid0 && k < 20) begin
            chk("sel_drive", {24'd0, alu_sel0}, {24'd0, esel});
            chk("op1_drive", {24'd0, alu_op1_0}, {24'd0, a});
            chk("op2_drive", {24'd0, alu_op2_0}, {24'd0, b});
            chk("busy_drive", {31'd0, busy0}, 32'd1);
            chk("cmd_ready_drive", {31'd0, cmd_ready0}, 32'd0);
            @(negedge clk);
            k++;
        end
        chk("latency", k, S0);
        chk("rsp_data", {24'd0, rsp_data0}, {24'd0, expd});
        chk("rsp_opcode", {29'd0, rsp_opcode0}, {29'd0, op});
        chk("sel_done", {24'd0, alu_sel0}, 32'd0);
        chk("op1_hold", {24'd0, alu_op1_0}, {24'd0, a});
        held = rsp_data0;
        for (int i = 0; i < stall; i++) begin
            cmd_valid0 = 1'b1;
            cmd_opcode0 = 3'($urandom); cmd_op1_0 = 8'($urandom); cmd_op2_0 = 8'($urandom);
            @(negedge clk);
            chk("stall_valid", {31'd0, rsp_valid0}, 32'd1);
            chk("stall_data", {24'd0, rsp_data0}, {24'd0, held});
            chk("stall_cmd_ready", {31'd0, cmd_ready0}, 32'd0);
            chk("stall_count", {28'd0, op_count0}, exp_cnt);
        end
        cmd_valid0 = 1'b0;
        rsp_ready0 = 1'b1;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        chk("rsp_drop", {31'd0, rsp_valid0}, 32'd0);
        chk("cmd_ready_back", {31'd0, cmd_ready0}, 32'd1);
        chk("busy_idle", {31'd0, busy0}, 32'd0);
        chk("op_count", {28'd0, op_count0}, exp_cnt);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         stall;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nacc, nres, t[2];
        logic [7:0] asel[2], res[2];
        logic pbusy;
        logic [2:0] rop;
        logic [7:0] ra, rb;

        // Hand-computed vectors: one per opcode, AND and stalled NOT first.
        vecs[0] = '{3'd5, 8'hCC, 8'hAA, 0, 8'h88};
        vecs[1] = '{3'd7, 8'h0F, 8'h55, 5, 8'hF0};
        vecs[2] = '{3'd0, 8'h7F, 8'h01, 0, 8'h80};
        vecs[3] = '{3'd1, 8'h10, 8'h01, 1, 8'h0F};
        vecs[4] = '{3'd2, 8'h41, 8'h00, 0, 8'h82};
        vecs[5] = '{3'd3, 8'h81, 8'h00, 2, 8'h40};
        vecs[6] = '{3'd4, 8'hF0, 8'h3C, 0, 8'hCC};
        vecs[7] = '{3'd6, 8'h30, 8'h03, 0, 8'h33};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready0}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
        chk("rst_sel", {24'd0, alu_sel0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_count", {28'd0, op_count0}, 32'd0);
        rst_n = 1'b1;

        // Reset asserted mid-DRIVE aborts the AND operation.
        @(negedge clk);
        cmd_valid0 = 1'b1; cmd_opcode0 = 3'd5; cmd_op1_0 = 8'hCC; cmd_op2_0 = 8'hAA;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        chk("pre_abort_sel", {24'd0, alu_sel0}, 32'h20);
        chk("pre_abort_busy", {31'd0, busy0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cmd_ready", {31'd0, cmd_ready0}, 32'd1);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_sel", {24'd0, alu_sel0}, 32'd0);
        chk("abort_op1", {24'd0, alu_op1_0}, 32'd0);
        chk("abort_op2", {24'd0, alu_op2_0}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
        chk("abort_rsp_data", {24'd0, rsp_data0}, 32'd0);
        chk("abort_rsp_opcode", {29'd0, rsp_opcode0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_abort_rsp_valid", {31'd0, rsp_valid0}, 32'd0);
            chk("post_abort_busy", {31'd0, busy0}, 32'd0);
        end
        chk("post_abort_count", {28'd0, op_count0}, 32'd0);

        // Table vectors (one-hot sweep, AND, stalled NOT).
        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].exp);

        // Random transactions up to 17 completions, then the counter wrap.
        for (int i = 0; i < 9; i++) begin
            rop = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            do_txn(rop, ra, rb, int'($urandom_range(0, 3)), ref_fn(rop, ra, rb));
        end
        chk("wrap", {28'd0, op_count0}, 32'd1);

        // Back-to-back with cmd_valid and rsp_ready held high.
        @(negedge clk);
        cmd_valid0 = 1'b1; cmd_opcode0 = 3'd0; cmd_op1_0 = 8'h7F; cmd_op2_0 = 8'h01;
        rsp_ready0 = 1'b1;
        pbusy = busy0; nacc = 0; nres = 0;
        t[0] = 0; t[1] = 0; asel[0] = '0; asel[1] = '0; res[0] = '0; res[1] = '0;
        for (int k = 0; k < 40 && nres < 2; k++) begin
            @(negedge clk);
            if (busy0 && !pbusy && nacc < 2) begin
                t[nacc] = k;
                asel[nacc] = alu_sel0;
                nacc++;
                if (nacc == 1) begin
                    cmd_opcode0 = 3'd6; cmd_op1_0 = 8'h30; cmd_op2_0 = 8'h03;
                end else begin
                    cmd_valid0 = 1'b0;
                end
            end
            if (rsp_valid0 && nres < 2) begin
                res[nres] = rsp_data0;
                nres++;
            end
            pbusy = busy0;
        end
        cmd_valid0 = 1'b0;
        @(negedge clk);
        rsp_ready0 = 1'b0;
        exp_cnt = (exp_cnt + 2) % 16;
        chk("b2b_accepts", nacc, 2);
        chk("b2b_results", nres, 2);
        chk("b2b_interval", t[1] - t[0], S0 + 2);
        chk("b2b_sel0", {24'd0, asel[0]}, 32'h01);
        chk("b2b_sel1", {24'd0, asel[1]}, 32'h40);
        chk("b2b_res0", {24'd0, res[0]}, 32'h80);
        chk("b2b_res1", {24'd0, res[1]}, 32'h33);
        chk("b2b_count", {28'd0, op_count0}, exp_cnt);

        // More randomized traffic against the reference model.
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom);
            do_txn(rop, ra, rb, int'($urandom_range(0, 3)), ref_fn(rop, ra, rb));
        end

        // SETTLE_CYCLES=1: DRIVE lasts a single cycle.
        @(negedge clk);
        cmd_valid1 = 1'b1; cmd_opcode1 = 3'd5; cmd_op1_1 = 8'hCC; cmd_op2_1 = 8'hAA;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        chk("s1_sel", {24'd0, alu_sel1}, 32'h20);
        chk("s1_busy", {31'd0, busy1}, 32'd1);
        chk("s1_no_rsp_yet", {31'd0, rsp_valid1}, 32'd0);
        @(negedge clk);
        chk("s1_rsp_valid", {31'd0, rsp_valid1}, 32'd1);
        chk("s1_rsp_data", {24'd0, rsp_data1}, 32'h88);
        chk("s1_sel_done", {24'd0, alu_sel1}, 32'd0);
        @(negedge clk);
        chk("s1_rsp_drop", {31'd0, rsp_valid1}, 32'd0);
        chk("s1_count", {16'd0, op_count1}, 32'd1);
        chk("s1_cmd_ready", {31'd0, cmd_ready1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side driver for the 8-bit ALU datapath.
- Accepts an opcode/operand request over a valid/ready handshake and decodes the 3-bit opcode into the ALU's 8-bit one-hot select bus.
- Drives registered operands, holds them for a programmable settle window, then captures the ALU answer and returns it over a valid/ready response channel.
- Sits between the instruction-issue logic and the combinational ALU.

Parameters:
SETTLE_CYCLES, 2, cycles operands/select are held before the ALU answer is sampled; legal range 1..15
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  request present
cmd_ready  output  1  sequencer can accept a request
cmd_opcode  input  3  operation code; selects the one-hot bit index of alu_sel
cmd_op1  input  8  operand 1
cmd_op2  input  8  operand 2
alu_op1  output  8  registered operand 1 to ALU
alu_op2  output  8  registered operand 2 to ALU
alu_sel  output  8  one-hot ALU select lines
alu_ans  input  8  ALU combinational result
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  8  captured ALU result
rsp_opcode  output  3  opcode of the returned result
busy  output  1  high in any state other than IDLE
op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0 except cmd_ready=1.
  - State IDLE, settle counter 0.
- Reset mid-operation aborts immediately: no response is produced, and op_count is not incremented.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE:
  - cmd_ready=1, alu_sel=0.
  - On cmd_valid at an edge:
    - latch cmd_opcode, cmd_op1 and cmd_op2 into alu_op1/alu_op2;
    - set alu_sel = 1 << cmd_opcode (exactly one bit set);
    - load cnt = SETTLE_CYCLES-1; cmd_ready->0; go to DRIVE.
- Opcode map:
  - Opcode n asserts only alu_sel[n].
  - 5 = AND, 6 = OR, 7 = NOT (op1 only; op2 is still driven unchanged).
  - 0..4 = arithmetic group.
- DRIVE:
  - alu_op1, alu_op2 and alu_sel are stable and never change.
  - If cnt != 0, decrement.
  - If cnt == 0 at an edge:
    - rsp_data <= alu_ans, rsp_opcode <= latched opcode;
    - rsp_valid <= 1, alu_sel <= 0;
    - go to DONE.
- Latency: accepting edge E produces rsp_valid high after edge E+SETTLE_CYCLES. alu_ans is sampled at that same edge.
- DONE:
  - rsp_valid, rsp_data and rsp_opcode are held stable until rsp_ready.
  - At an edge with rsp_ready=1:
    - rsp_valid <= 0; op_count <= op_count+1 (wraps 0xFFFF->0x0000);
    - cmd_ready <= 1; go to IDLE.
- Handshake rules:
  - A new command is not accepted in DRIVE or DONE (cmd_ready=0). cmd_valid may stay high without effect.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles when rsp_ready is tied high.
- Boundaries:
  - SETTLE_CYCLES=1: DRIVE lasts exactly one cycle.
  - rsp_ready held low indefinitely: stall in DONE with data stable.
  - cmd_* changes during DRIVE/DONE: ignored.
  - busy = (state != IDLE).
- alu_op1 and alu_op2 retain their last values in IDLE and DONE. Only alu_sel returns to 0.

Test Plan:
- Reset and initial state:
  - Stimulus: assert rst_n=0 mid-DRIVE, after a command with opcode 5.
  - Required: all outputs 0 immediately; cmd_ready=1; no rsp_valid after release; op_count=0.
- AND operation:
  - Stimulus: opcode 5, op1=0xCC, op2=0xAA, SETTLE_CYCLES=2. Bench ALU model returns 0x88.
  - Required: alu_sel=0x20 for exactly 2 cycles; rsp_valid rises 2 edges after accept; rsp_data=0x88, rsp_opcode=5.
- NOT operation with stalled consumer:
  - Stimulus: opcode 7, op1=0x0F; model returns 0xF0; rsp_ready held low for 5 cycles.
  - Required: rsp_data=0xF0 held stable; cmd_ready=0 throughout; command ignored; single increment of op_count after rsp_ready.
- Back-to-back commands:
  - Stimulus: cmd_valid and rsp_ready held high; issue opcode 0 (model: op1+op2, 0x7F+0x01), then opcode 6 (0x30|0x03).
  - Required: results 0x80 then 0x33; second accept exactly SETTLE_CYCLES+2 cycles after the first; alu_sel 0x01 then 0x40.
- One-hot sweep:
  - Stimulus: opcodes 0..7 in turn.
  - Required: alu_sel = 0x01,0x02,...,0x80; exactly one bit set during DRIVE; 0x00 otherwise.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 completed operations.
  - Required: op_count reads 0x1 after the 17th rsp handshake.
